// File: rtl/i2c_write_feeder.sv
// i2c_write_feeder: write-side front end for the I2C master.
// Bytes are queued in a show-ahead FIFO. A write command (address + byte count) waits for its
// data and for the master to be ready, launches with a one-cycle enable, then feeds the master
// one byte per valid pulse. A stalled master makes the feeder discard the rest of the command
// and report an error.
module i2c_write_feeder #(
   parameter int DEPTH          = 16,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int CONTINUOUS     = 1
) (
   input  logic                    clk_in,
   input  logic                    rst,
   input  logic                    push_in,
   input  logic [7:0]              push_data_in,
   output logic                    full_out,
   output logic [$clog2(DEPTH):0]  level_out,
   output logic                    ovf_out,
   input  logic                    cmd_valid_in,
   input  logic [6:0]              cmd_addr_in,
   input  logic [5:0]              cmd_bytes_in,
   output logic                    cmd_ready_out,
   output logic                    busy_out,
   output logic                    done_out,
   output logic                    err_out,
   input  logic                    m_ready_in,
   input  logic                    m_valid_in,
   output logic                    m_en_out,
   output logic                    m_rd_wr_out,
   output logic                    m_continuous_out,
   output logic [6:0]              m_address_out,
   output logic [7:0]              m_wr_data_out,
   output logic [5:0]              m_wr_data_bytes_out
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [6:0]    DEPTH_C    = 7'(DEPTH);
   localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
   localparam logic [WW-1:0] WD_LAST    = WW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_DATA,
      ST_WAIT_READY,
      ST_LAUNCH,
      ST_XFER,
      ST_ABORT,
      ST_DONE
   } state_t;

   state_t          state_q, state_d;

   logic [7:0]      mem_q [DEPTH];
   logic [7:0]      mem_d [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]   level_q, level_d;
   logic            ovf_q, ovf_d;

   logic [6:0]      addr_q, addr_d;
   logic [5:0]      bytes_q, bytes_d;
   logic [5:0]      remaining_q, remaining_d;
   logic [WW-1:0]   watchdog_q, watchdog_d;
   logic            err_q, err_d;

   logic            pop_req;
   logic            pop;
   logic            push_ok;
   logic            full;
   logic [6:0]      level_wide;

   assign full       = (level_q == FULL_LEVEL);
   assign level_wide = 7'(level_q);

   // Command sequencing: accept, wait for data and master, launch, feed bytes, abort or finish.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      bytes_d     = bytes_q;
      remaining_d = remaining_q;
      watchdog_d  = watchdog_q;
      err_d       = 1'b0;
      pop_req     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid_in) begin
               addr_d  = cmd_addr_in;
               bytes_d = cmd_bytes_in;
               if ((cmd_bytes_in == 6'd0) || ({1'b0, cmd_bytes_in} > DEPTH_C)) begin
                  err_d = 1'b1;
               end else begin
                  state_d = ST_WAIT_DATA;
               end
            end
         end

         ST_WAIT_DATA: begin
            if (level_wide >= {1'b0, bytes_q}) begin
               state_d = ST_WAIT_READY;
            end
         end

         ST_WAIT_READY: begin
            if (m_ready_in) begin
               state_d = ST_LAUNCH;
            end
         end

         ST_LAUNCH: begin
            remaining_d = bytes_q;
            watchdog_d  = '0;
            state_d     = ST_XFER;
         end

         ST_XFER: begin
            if (m_valid_in) begin
               pop_req     = 1'b1;
               remaining_d = remaining_q - 6'd1;
               watchdog_d  = '0;
               if (remaining_q == 6'd1) begin
                  state_d = ST_DONE;
               end
            end else if (watchdog_q == WD_LAST) begin
               state_d = ST_ABORT;
            end else begin
               watchdog_d = watchdog_q + WW'(1);
            end
         end

         ST_ABORT: begin
            if (remaining_q != 6'd0) begin
               pop_req     = 1'b1;
               remaining_d = remaining_q - 6'd1;
            end else begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FIFO bookkeeping: a push into a full FIFO only succeeds when a pop frees a slot that cycle.
   always_comb begin
      pop      = pop_req && (level_q != '0);
      push_ok  = push_in && (!full || pop);
      ovf_d    = push_in && full && !pop;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;

      if (push_ok) begin
         mem_d[wr_ptr_q] = push_data_in;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push_ok && !pop) begin
         level_d = level_q + LW'(1);
      end else if (pop && !push_ok) begin
         level_d = level_q - LW'(1);
      end
   end

   // State, FIFO storage and command registers; reset empties everything at once.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         mem_q       <= '{default: '0};
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         ovf_q       <= 1'b0;
         addr_q      <= '0;
         bytes_q     <= '0;
         remaining_q <= '0;
         watchdog_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         ovf_q       <= ovf_d;
         addr_q      <= addr_d;
         bytes_q     <= bytes_d;
         remaining_q <= remaining_d;
         watchdog_q  <= watchdog_d;
         err_q       <= err_d;
      end
   end

   assign full_out            = full;
   assign level_out           = level_q;
   assign ovf_out             = ovf_q;
   assign cmd_ready_out       = (state_q == ST_IDLE);
   assign busy_out            = (state_q != ST_IDLE);
   assign done_out            = (state_q == ST_DONE);
   assign err_out             = err_q;
   assign m_en_out            = (state_q == ST_LAUNCH);
   assign m_rd_wr_out         = 1'b0;
   assign m_continuous_out    = (CONTINUOUS != 0);
   assign m_address_out       = addr_q;
   assign m_wr_data_out       = mem_q[rd_ptr_q];
   assign m_wr_data_bytes_out = bytes_q;

endmodule

// File: tb/tb_i2c_write_feeder.sv
// Testbench for i2c_write_feeder: directed scenarios, a queue-based reference model
// compared every cycle, and literal expectations pinned at key points.
module tb_i2c_write_feeder;

   localparam int T_DEPTH    = 16;
   localparam int T_TIMEOUT  = 64;
   localparam int LW         = $clog2(T_DEPTH) + 1;
   localparam int MAX_CYCLES = 20000;
   localparam int PIN_SLOTS  = 256;

   localparam int SEL_MEN   = 0;
   localparam int SEL_DONE  = 1;
   localparam int SEL_ERR   = 2;
   localparam int SEL_BUSY  = 3;
   localparam int SEL_READY = 4;
   localparam int SEL_LEVEL = 5;
   localparam int SEL_FULL  = 6;
   localparam int SEL_OVF   = 7;
   localparam int SEL_ADDR  = 8;
   localparam int SEL_DATA  = 9;
   localparam int SEL_BYTES = 10;
   localparam int SEL_CONT  = 11;

   localparam int PH_IDLE       = 0;
   localparam int PH_NEED_DATA  = 1;
   localparam int PH_NEED_READY = 2;
   localparam int PH_LAUNCH     = 3;
   localparam int PH_SENDING    = 4;
   localparam int PH_DRAINING   = 5;
   localparam int PH_FINISHED   = 6;

   logic          clk_in = 1'b0;
   logic          rst = 1'b1;
   logic          push_in = 1'b0;
   logic [7:0]    push_data_in = '0;
   logic          full_out;
   logic [LW-1:0] level_out;
   logic          ovf_out;
   logic          cmd_valid_in = 1'b0;
   logic [6:0]    cmd_addr_in = '0;
   logic [5:0]    cmd_bytes_in = '0;
   logic          cmd_ready_out;
   logic          busy_out;
   logic          done_out;
   logic          err_out;
   logic          m_ready_in = 1'b0;
   logic          m_valid_in = 1'b0;
   logic          m_en_out;
   logic          m_rd_wr_out;
   logic          m_continuous_out;
   logic [6:0]    m_address_out;
   logic [7:0]    m_wr_data_out;
   logic [5:0]    m_wr_data_bytes_out;

   always #5 clk_in = ~clk_in;

   i2c_write_feeder #(
      .DEPTH          (T_DEPTH),
      .TIMEOUT_CYCLES (T_TIMEOUT),
      .CONTINUOUS     (1)
   ) dut (
      .clk_in              (clk_in),
      .rst                 (rst),
      .push_in             (push_in),
      .push_data_in        (push_data_in),
      .full_out            (full_out),
      .level_out           (level_out),
      .ovf_out             (ovf_out),
      .cmd_valid_in        (cmd_valid_in),
      .cmd_addr_in         (cmd_addr_in),
      .cmd_bytes_in        (cmd_bytes_in),
      .cmd_ready_out       (cmd_ready_out),
      .busy_out            (busy_out),
      .done_out            (done_out),
      .err_out             (err_out),
      .m_ready_in          (m_ready_in),
      .m_valid_in          (m_valid_in),
      .m_en_out            (m_en_out),
      .m_rd_wr_out         (m_rd_wr_out),
      .m_continuous_out    (m_continuous_out),
      .m_address_out       (m_address_out),
      .m_wr_data_out       (m_wr_data_out),
      .m_wr_data_bytes_out (m_wr_data_bytes_out)
   );

   // Reference model state: FIFO contents as a queue plus the command's progress.
   logic [7:0] mq[$];
   int         m_phase = PH_IDLE;
   int         m_left = 0;
   int         m_quiet = 0;
   logic [6:0] m_addr = '0;
   logic [5:0] m_bytes = '0;
   bit         m_err = 1'b0;
   bit         m_ovf = 1'b0;
   bit         model_ok = 1'b0;

   // Pinned literal expectations queued by the stimulus, evaluated by the compare process.
   string       pin_name [PIN_SLOTS];
   int          pin_sel  [PIN_SLOTS];
   logic [31:0] pin_exp  [PIN_SLOTS];
   int          pin_wr = 0;
   int          pin_rd = 0;
   bit          end_req = 1'b0;

   int checks_total = 0;
   int checks_passed = 0;
   int cycle_count = 0;

   // Advance the model by one clock edge using the inputs the DUT sees at that edge.
   always @(posedge clk_in) begin
      bit take;
      bit err_now;
      bit was_full;
      take    = 1'b0;
      err_now = 1'b0;
      if (rst) begin
         mq.delete();
         m_phase  = PH_IDLE;
         m_left   = 0;
         m_quiet  = 0;
         m_addr   = '0;
         m_bytes  = '0;
         m_err    = 1'b0;
         m_ovf    = 1'b0;
         model_ok = 1'b1;
      end else if (model_ok) begin
         case (m_phase)
            PH_IDLE: begin
               if (cmd_valid_in) begin
                  m_addr  = cmd_addr_in;
                  m_bytes = cmd_bytes_in;
                  if (cmd_bytes_in == 0 || int'(cmd_bytes_in) > T_DEPTH) err_now = 1'b1;
                  else m_phase = PH_NEED_DATA;
               end
            end
            PH_NEED_DATA: if (mq.size() >= int'(m_bytes)) m_phase = PH_NEED_READY;
            PH_NEED_READY: if (m_ready_in) m_phase = PH_LAUNCH;
            PH_LAUNCH: begin
               m_left  = int'(m_bytes);
               m_quiet = 0;
               m_phase = PH_SENDING;
            end
            PH_SENDING: begin
               if (m_valid_in) begin
                  take = 1'b1;
                  if (m_left == 1) m_phase = PH_FINISHED;
                  m_left  = m_left - 1;
                  m_quiet = 0;
               end else if (m_quiet == T_TIMEOUT - 1) begin
                  m_phase = PH_DRAINING;
               end else begin
                  m_quiet = m_quiet + 1;
               end
            end
            PH_DRAINING: begin
               if (m_left > 0) begin
                  take   = 1'b1;
                  m_left = m_left - 1;
               end else begin
                  err_now = 1'b1;
                  m_phase = PH_IDLE;
               end
            end
            default: m_phase = PH_IDLE;
         endcase
         was_full = (mq.size() == T_DEPTH);
         take     = take && (mq.size() > 0);
         m_ovf    = push_in && was_full && !take;
         if (take) void'(mq.pop_front());
         if (push_in && (!was_full || take)) mq.push_back(push_data_in);
         m_err = err_now;
      end
   end

   function automatic logic [31:0] dutSel(input int sel);
      case (sel)
         SEL_MEN:   return 32'(m_en_out);
         SEL_DONE:  return 32'(done_out);
         SEL_ERR:   return 32'(err_out);
         SEL_BUSY:  return 32'(busy_out);
         SEL_READY: return 32'(cmd_ready_out);
         SEL_LEVEL: return 32'(level_out);
         SEL_FULL:  return 32'(full_out);
         SEL_OVF:   return 32'(ovf_out);
         SEL_ADDR:  return 32'(m_address_out);
         SEL_DATA:  return 32'(m_wr_data_out);
         SEL_BYTES: return 32'(m_wr_data_bytes_out);
         SEL_CONT:  return 32'(m_continuous_out);
         default:   return 32'hDEAD_BEEF;
      endcase
   endfunction

   task automatic compareOne(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks_total = checks_total + 1;
      if (act === exp) checks_passed = checks_passed + 1;
      else $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cycle_count, act, exp);
   endtask

   // Compare process: model vs DUT every cycle, then pinned literals, then the summary.
   always @(negedge clk_in) begin
      cycle_count = cycle_count + 1;
      if (model_ok) begin
         compareOne("cmd_ready", 32'(cmd_ready_out), 32'(m_phase == PH_IDLE));
         compareOne("busy", 32'(busy_out), 32'(m_phase != PH_IDLE));
         compareOne("m_en", 32'(m_en_out), 32'(m_phase == PH_LAUNCH));
         compareOne("done", 32'(done_out), 32'(m_phase == PH_FINISHED));
         compareOne("err", 32'(err_out), 32'(m_err));
         compareOne("ovf", 32'(ovf_out), 32'(m_ovf));
         compareOne("level", 32'(level_out), 32'(mq.size()));
         compareOne("full", 32'(full_out), 32'(mq.size() == T_DEPTH));
         compareOne("address", 32'(m_address_out), 32'(m_addr));
         compareOne("byte_count", 32'(m_wr_data_bytes_out), 32'(m_bytes));
         compareOne("rd_wr", 32'(m_rd_wr_out), 32'd0);
         compareOne("continuous", 32'(m_continuous_out), 32'd1);
         if (mq.size() > 0) compareOne("head_data", 32'(m_wr_data_out), 32'(mq[0]));
      end
      while (pin_rd < pin_wr) begin
         compareOne(pin_name[pin_rd], dutSel(pin_sel[pin_rd]), pin_exp[pin_rd]);
         pin_rd = pin_rd + 1;
      end
      if (end_req || cycle_count >= MAX_CYCLES) begin
         if (!end_req) begin
            checks_total = checks_total + 1;
            $display("[TB] FAIL run_limit: ran %0d cycles, required finish before %0d", cycle_count, MAX_CYCLES);
         end
         $display("%0d/%0d checks passed", checks_passed, checks_total);
         $finish;
      end
   end

   // Queue a literal expectation for the current cycle's DUT outputs.
   task automatic checkOutput(input string name, input int sel, input logic [31:0] exp);
      if (pin_wr < PIN_SLOTS) begin
         pin_name[pin_wr] = name;
         pin_sel[pin_wr]  = sel;
         pin_exp[pin_wr]  = exp;
         pin_wr = pin_wr + 1;
      end
   endtask

   // Drive one cycle of inputs (m_ready_in and rst are left as they are) and step past the edge.
   task automatic applyStimulus(input logic push, input logic [7:0] pdata, input logic cvalid,
                                input logic [6:0] caddr, input logic [5:0] cbytes, input logic mvalid);
      push_in      = push;
      push_data_in = pdata;
      cmd_valid_in = cvalid;
      cmd_addr_in  = caddr;
      cmd_bytes_in = cbytes;
      m_valid_in   = mvalid;
      @(posedge clk_in);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0, 7'h00, 6'd0, 1'b0);
   endtask

   task automatic pushByte(input logic [7:0] b);
      applyStimulus(1'b1, b, 1'b0, 7'h00, 6'd0, 1'b0);
   endtask

   task automatic issueCmd(input logic [6:0] a, input logic [5:0] n);
      applyStimulus(1'b0, 8'h00, 1'b1, a, n, 1'b0);
   endtask

   task automatic validPulse();
      applyStimulus(1'b0, 8'h00, 1'b0, 7'h00, 6'd0, 1'b1);
   endtask

   task automatic waitHigh(input string name, input int sel, input int budget);
      int n;
      n = 0;
      while (dutSel(sel) != 32'd1 && n < budget) begin
         idle(1);
         n = n + 1;
      end
      checkOutput(name, sel, 32'd1);
   endtask

   task automatic pulseReset();
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
   endtask

   initial begin
      $display("[TB] starting i2c_write_feeder bench");
      idle(2);
      rst = 1'b0;
      checkOutput("reset_cmd_ready", SEL_READY, 32'd1);
      checkOutput("reset_busy", SEL_BUSY, 32'd0);
      checkOutput("reset_level", SEL_LEVEL, 32'd0);
      checkOutput("reset_m_en", SEL_MEN, 32'd0);
      checkOutput("reset_continuous", SEL_CONT, 32'd1);
      checkOutput("reset_data", SEL_DATA, 32'd0);

      // Scenario 1: buffered data, ready master, three bytes fed on valid pulses.
      pushByte(8'hA1);
      pushByte(8'hB2);
      pushByte(8'hC3);
      m_ready_in = 1'b1;
      issueCmd(7'h50, 6'd3);
      idle(2);
      checkOutput("s1_launch_en", SEL_MEN, 32'd1);
      checkOutput("s1_address", SEL_ADDR, 32'h50);
      checkOutput("s1_bytes", SEL_BYTES, 32'd3);
      checkOutput("s1_first_byte", SEL_DATA, 32'hA1);
      idle(1);
      checkOutput("s1_en_single_cycle", SEL_MEN, 32'd0);
      validPulse();
      checkOutput("s1_second_byte", SEL_DATA, 32'hB2);
      idle(1);
      validPulse();
      checkOutput("s1_third_byte", SEL_DATA, 32'hC3);
      validPulse();
      checkOutput("s1_done", SEL_DONE, 32'd1);
      checkOutput("s1_level_after", SEL_LEVEL, 32'd0);
      idle(1);
      checkOutput("s1_done_cleared", SEL_DONE, 32'd0);

      // Scenario 2: command waits for data, then for the master.
      m_ready_in = 1'b0;
      issueCmd(7'h3A, 6'd2);
      idle(3);
      checkOutput("s2_waiting_busy", SEL_BUSY, 32'd1);
      checkOutput("s2_waiting_no_en", SEL_MEN, 32'd0);
      checkOutput("s2_waiting_not_ready", SEL_READY, 32'd0);
      pushByte(8'h11);
      pushByte(8'h22);
      idle(2);
      checkOutput("s2_held_no_en", SEL_MEN, 32'd0);
      checkOutput("s2_level", SEL_LEVEL, 32'd2);
      m_ready_in = 1'b1;
      waitHigh("s2_launch", SEL_MEN, 8);
      checkOutput("s2_address", SEL_ADDR, 32'h3A);
      checkOutput("s2_first_byte", SEL_DATA, 32'h11);
      idle(1);
      validPulse();
      idle(1);
      validPulse();
      waitHigh("s2_done", SEL_DONE, 4);
      idle(1);

      // Scenario 3: illegal byte counts are rejected without touching the FIFO.
      pushByte(8'h77);
      issueCmd(7'h22, 6'd0);
      checkOutput("s3_zero_err", SEL_ERR, 32'd1);
      checkOutput("s3_zero_busy", SEL_BUSY, 32'd0);
      idle(1);
      checkOutput("s3_err_cleared", SEL_ERR, 32'd0);
      issueCmd(7'h23, 6'(T_DEPTH + 1));
      checkOutput("s3_big_err", SEL_ERR, 32'd1);
      checkOutput("s3_big_busy", SEL_BUSY, 32'd0);
      checkOutput("s3_level_kept", SEL_LEVEL, 32'd1);
      idle(1);
      pulseReset();
      checkOutput("s3_reset_level", SEL_LEVEL, 32'd0);

      // Scenario 4: overflow, then push and pop together at full.
      for (int i = 0; i <= T_DEPTH; i++) pushByte(8'h30 + 8'(i));
      checkOutput("s4_level_full", SEL_LEVEL, 32'd16);
      checkOutput("s4_full", SEL_FULL, 32'd1);
      checkOutput("s4_ovf", SEL_OVF, 32'd1);
      idle(1);
      checkOutput("s4_ovf_single", SEL_OVF, 32'd0);
      issueCmd(7'h41, 6'd1);
      waitHigh("s4_launch", SEL_MEN, 6);
      idle(1);
      applyStimulus(1'b1, 8'h50, 1'b0, 7'h00, 6'd0, 1'b1);
      checkOutput("s4_pushpop_level", SEL_LEVEL, 32'd16);
      checkOutput("s4_pushpop_no_ovf", SEL_OVF, 32'd0);
      checkOutput("s4_pushpop_head", SEL_DATA, 32'h31);
      checkOutput("s4_done", SEL_DONE, 32'd1);
      idle(1);

      // Scenario 5: master stalls after one byte; the remaining three are discarded.
      issueCmd(7'h42, 6'd4);
      waitHigh("s5_launch", SEL_MEN, 6);
      idle(1);
      validPulse();
      checkOutput("s5_level_after_pulse", SEL_LEVEL, 32'd15);
      waitHigh("s5_abort_err", SEL_ERR, T_TIMEOUT + 20);
      checkOutput("s5_level_after_abort", SEL_LEVEL, 32'd12);
      checkOutput("s5_head_after_abort", SEL_DATA, 32'h35);
      checkOutput("s5_idle_after_abort", SEL_BUSY, 32'd0);
      idle(1);

      // Scenario 6: reset in the middle of a transfer.
      issueCmd(7'h43, 6'd2);
      waitHigh("s6_launch", SEL_MEN, 6);
      idle(2);
      checkOutput("s6_busy_before", SEL_BUSY, 32'd1);
      rst = 1'b1;
      pushByte(8'h99);
      rst = 1'b0;
      checkOutput("s6_busy", SEL_BUSY, 32'd0);
      checkOutput("s6_level", SEL_LEVEL, 32'd0);
      checkOutput("s6_m_en", SEL_MEN, 32'd0);
      checkOutput("s6_cmd_ready", SEL_READY, 32'd1);
      validPulse();
      checkOutput("s6_stray_valid_ignored", SEL_BUSY, 32'd0);

      idle(2);
      end_req = 1'b1;
   end

endmodule
